// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
//   ifu_state_e    : fetch control states
//   IFU_ADDR_W     : default ROM address / PC width
//   IFU_DATA_W     : default instruction word width
//   IFU_START_ADDR : default PC after reset and on start
package ifu_pkg;

  localparam int unsigned IFU_ADDR_W     = 6;
  localparam int unsigned IFU_DATA_W     = 32;
  localparam int unsigned IFU_START_ADDR = 0;

  typedef enum logic [1:0] {
    IFU_IDLE   = 2'd0,
    IFU_FETCH  = 2'd1,
    IFU_DRAIN  = 2'd2,
    IFU_HALTED = 2'd3
  } ifu_state_e;

endpackage : ifu_pkg

// File: rtl/ifu_out_buf.sv
// Output stage of the fetch unit: holds fetched words until decode takes them.
// Build option IFU_SKID_EN: when defined, a 2-entry FIFO (head + skid register)
// lets fetch run one word ahead of a stalled consumer; when undefined, a single
// output register is used.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   push            : write push_data/push_pc (caller only pushes when can_push_c)
//   flush           : discard every held entry (dominates push)
//   out_ready       : consumer accepts head when out_valid & out_ready
//   out_valid/data/pc : head entry, driven straight from flops
//   can_push_c      : a push this cycle will be absorbed
//   drained_c       : buffer will be empty after this cycle with no push
module ifu_out_buf #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_pc,
  output logic              can_push_c,
  output logic              drained_c
);

`ifdef IFU_SKID_EN

  logic              h_valid_q, h_valid_d;
  logic [DATA_W-1:0] h_data_q,  h_data_d;
  logic [ADDR_W-1:0] h_pc_q,    h_pc_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [ADDR_W-1:0] s_pc_q,    s_pc_d;
  logic              pop_c;

  assign pop_c      = h_valid_q & out_ready;
  // Full buffer still takes a word when the head leaves the same cycle.
  assign can_push_c = !s_valid_q | out_ready;
  assign drained_c  = !h_valid_q | (!s_valid_q & out_ready);

  // Head/skid update: skid entry always slides into the head on a pop.
  always_comb begin
    h_valid_d = h_valid_q;
    h_data_d  = h_data_q;
    h_pc_d    = h_pc_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_pc_d    = s_pc_q;
    if (flush) begin
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (pop_c) begin
      if (s_valid_q) begin
        h_valid_d = 1'b1;
        h_data_d  = s_data_q;
        h_pc_d    = s_pc_q;
        s_valid_d = push;
        if (push) begin
          s_data_d = push_data;
          s_pc_d   = push_pc;
        end
      end else if (push) begin
        h_valid_d = 1'b1;
        h_data_d  = push_data;
        h_pc_d    = push_pc;
      end else begin
        h_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!h_valid_q) begin
        h_valid_d = 1'b1;
        h_data_d  = push_data;
        h_pc_d    = push_pc;
      end else begin
        s_valid_d = 1'b1;
        s_data_d  = push_data;
        s_pc_d    = push_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_valid_q <= 1'b0;
      h_data_q  <= '0;
      h_pc_q    <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_pc_q    <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      h_data_q  <= h_data_d;
      h_pc_q    <= h_pc_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_pc_q    <= s_pc_d;
    end
  end

  assign out_valid = h_valid_q;
  assign out_data  = h_data_q;
  assign out_pc    = h_pc_q;

`else

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic              pop_c;

  assign pop_c      = valid_q & out_ready;
  assign can_push_c = !valid_q | out_ready;
  assign drained_c  = !valid_q | out_ready;

  // Single register: flush beats push, push beats a plain pop.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d = 1'b1;
      data_d  = push_data;
      pc_d    = push_pc;
    end else if (pop_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_pc    = pc_q;

`endif

endmodule : ifu_out_buf

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses the combinational instruction
// ROM and hands fetched words to decode over valid/ready. Handles jump
// redirects, halt/drain and PC wrap.
// Build option IFU_SKID_EN selects the 2-entry output FIFO in ifu_out_buf.
// Ports:
//   CLK, RST        : clock, synchronous active-low reset
//   start           : leave IDLE/HALTED and restart at START_ADDR
//   halt_req        : stop fetching, finish handing over held words
//   jump_valid/addr : redirect the PC (FETCH only)
//   imem_addr       : ROM address, always equal to the PC
//   imem_data       : ROM word for imem_addr, same cycle
//   inst_valid/ready, inst_data, inst_pc : decode handshake and payload
//   pc_wrap         : one-cycle pulse after the PC rolls over from max to 0
//   fetch_count     : saturating count of words accepted by decode
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W     = IFU_ADDR_W,
  parameter int unsigned DATA_W     = IFU_DATA_W,
  parameter int unsigned START_ADDR = IFU_START_ADDR
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              halt_req,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              pc_wrap,
  output logic [15:0]       fetch_count
);

  localparam int unsigned       CNT_W    = 16;
  localparam logic [ADDR_W-1:0] PC_MAX   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PC_START = ADDR_W'(START_ADDR);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_wrap_q, pc_wrap_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

  logic buf_push_c;
  logic buf_flush_c;
  logic buf_can_push_c;
  logic buf_drained_c;
  logic handshake_c;

  assign handshake_c = inst_valid & inst_ready;

  // Control FSM, PC update and acceptance counter.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_wrap_d     = 1'b0;
    fetch_count_d = fetch_count_q;
    buf_push_c    = 1'b0;
    buf_flush_c   = 1'b0;

    if (handshake_c && (fetch_count_q != CNT_MAX)) begin
      fetch_count_d = fetch_count_q + CNT_W'(1);
    end

    case (state_q)
      IFU_IDLE, IFU_HALTED: begin
        if (start) begin
          state_d = IFU_FETCH;
          pc_d    = PC_START;
        end
      end
      IFU_FETCH: begin
        // Halt outranks jump; jump outranks a normal load.
        if (halt_req) begin
          state_d = IFU_DRAIN;
        end else if (jump_valid) begin
          pc_d        = jump_addr;
          buf_flush_c = 1'b1;
        end else if (buf_can_push_c) begin
          buf_push_c = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
          pc_wrap_d  = (pc_q == PC_MAX);
        end
      end
      IFU_DRAIN: begin
        if (buf_drained_c) begin
          state_d = IFU_HALTED;
        end
      end
      default: begin
        state_d = IFU_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= IFU_IDLE;
      pc_q          <= PC_START;
      pc_wrap_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_wrap_q     <= pc_wrap_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  ifu_out_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk        (CLK),
    .rst_n      (RST),
    .push       (buf_push_c),
    .push_data  (imem_data),
    .push_pc    (pc_q),
    .flush      (buf_flush_c),
    .out_ready  (inst_ready),
    .out_valid  (inst_valid),
    .out_data   (inst_data),
    .out_pc     (inst_pc),
    .can_push_c (buf_can_push_c),
    .drained_c  (buf_drained_c)
  );

  assign imem_addr   = pc_q;
  assign pc_wrap     = pc_wrap_q;
  assign fetch_count = fetch_count_q;

endmodule : inst_fetch_unit

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a randomized
// stream compared against an in-order fetch reference model.
module tb_inst_fetch_unit;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic          halt_req;
  logic          jump_valid;
  logic [AW-1:0] jump_addr;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          pc_wrap;
  logic [15:0]   fetch_count;

  logic [DW-1:0] rom [DEPTH];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            exp_count = 0;

  inst_fetch_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .halt_req    (halt_req),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .pc_wrap     (pc_wrap),
    .fetch_count (fetch_count)
  );

  always #5 CLK = ~CLK;

  // Combinational ROM behaviour.
  assign imem_data = rom[imem_addr];

  // Advance one clock; the model counts handshakes presented this cycle.
  task automatic cycle();
    if (RST && inst_valid && inst_ready && exp_count < 65535) exp_count++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; start = 1'b0; halt_req = 1'b0; jump_valid = 1'b0;
    jump_addr = '0; inst_ready = 1'b0;
    cycle(); cycle();
    exp_count = 0;
    n_checks++;
    if (imem_addr !== 6'd0 || inst_valid !== 1'b0 || fetch_count !== 16'd0 ||
        inst_data !== 32'd0 || inst_pc !== 6'd0 || pc_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%0d valid=%b cnt=%0d data=%h pc=%0d wrap=%b, required 0/0/0/0/0/0",
               imem_addr, inst_valid, fetch_count, inst_data, inst_pc, pc_wrap);
    end
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (inst_valid !== 1'b0 || imem_addr !== 6'd0) begin
        n_fail++;
        $display("FAIL idle_hold: valid=%b addr=%0d, required 0/0", inst_valid, imem_addr);
      end
    end
  endtask

  task automatic test_stream();
    inst_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    n_checks++;
    if (imem_addr !== 6'd0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_latency: addr=%0d valid=%b, required 0/0", imem_addr, inst_valid);
    end
    cycle();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== AW'(k) || inst_data !== rom[k]) begin
        n_fail++;
        $display("FAIL stream_word: valid=%b pc=%0d data=%h, required 1/%0d/%h",
                 inst_valid, inst_pc, inst_data, k, rom[k]);
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    int cnt_before;
    inst_ready = 1'b0;
    cnt_before = exp_count;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 6'd4 || inst_data !== rom[4] ||
          fetch_count !== 16'(cnt_before)) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b pc=%0d data=%h cnt=%0d, required 1/4/%h/%0d",
                 inst_valid, inst_pc, inst_data, fetch_count, rom[4], cnt_before);
      end
    end
    inst_ready = 1'b1;
    cycle();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 6'd5 || inst_data !== rom[5] ||
        fetch_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b pc=%0d data=%h cnt=%0d, required 1/5/%h/%0d",
               inst_valid, inst_pc, inst_data, fetch_count, rom[5], exp_count);
    end
    cycle();
    cycle();
  endtask

  task automatic test_jump();
    jump_valid = 1'b1;
    jump_addr  = 6'd40;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 6'd7) begin
      n_fail++;
      $display("FAIL jump_pre: valid=%b pc=%0d, required 1/7", inst_valid, inst_pc);
    end
    cycle();
    jump_valid = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_bubble: valid=%b pc=%0d, required valid 0", inst_valid, inst_pc);
    end
    cycle();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 6'd40 || inst_data !== rom[40]) begin
      n_fail++;
      $display("FAIL jump_target: valid=%b pc=%0d data=%h, required 1/40/%h",
               inst_valid, inst_pc, inst_data, rom[40]);
    end
    cycle();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 6'd41 || fetch_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL jump_next: valid=%b pc=%0d cnt=%0d, required 1/41/%0d",
               inst_valid, inst_pc, fetch_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    jump_valid = 1'b1;
    jump_addr  = 6'd63;
    cycle();
    jump_valid = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0 || pc_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_bubble: valid=%b wrap=%b, required 0/0", inst_valid, pc_wrap);
    end
    cycle();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 6'd63 || pc_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_pulse: valid=%b pc=%0d wrap=%b, required 1/63/1", inst_valid, inst_pc, pc_wrap);
    end
    cycle();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 6'd0 || inst_data !== rom[0] || pc_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_after: valid=%b pc=%0d data=%h wrap=%b, required 1/0/%h/0",
               inst_valid, inst_pc, inst_data, pc_wrap, rom[0]);
    end
    jump_valid = 1'b1;
    jump_addr  = 6'd0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      jump_valid = 1'b0;
      n_checks++;
      if (pc_wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL jump0_wrap: wrap=%b in cycle %0d after jump to 0, required 0", pc_wrap, i);
      end
    end
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 6'd1) begin
      n_fail++;
      $display("FAIL jump0_stream: valid=%b pc=%0d, required 1/1", inst_valid, inst_pc);
    end
  endtask

  task automatic test_halt();
    logic [AW-1:0] held;
    logic [AW-1:0] addr_hold;
    held       = inst_pc;
    addr_hold  = imem_addr;
    inst_ready = 1'b0;
    halt_req   = 1'b1;
    jump_valid = 1'b1;
    jump_addr  = 6'd20;
    cycle();
    halt_req   = 1'b0;
    jump_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== held || imem_addr !== addr_hold) begin
        n_fail++;
        $display("FAIL halt_hold: valid=%b pc=%0d addr=%0d, required 1/%0d/%0d",
                 inst_valid, inst_pc, imem_addr, held, addr_hold);
      end
      cycle();
    end
    inst_ready = 1'b1;
    cycle();
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_drained: valid=%b pc=%0d, required valid 0", inst_valid, inst_pc);
    end
    jump_valid = 1'b1;
    jump_addr  = 6'd20;
    for (int i = 0; i < 4; i++) begin
      cycle();
      jump_valid = 1'b0;
      n_checks++;
      if (inst_valid !== 1'b0 || imem_addr !== addr_hold) begin
        n_fail++;
        $display("FAIL halted_idle: valid=%b addr=%0d, required 0/%0d", inst_valid, imem_addr, addr_hold);
      end
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    n_checks++;
    if (imem_addr !== 6'd0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_pc: addr=%0d valid=%b, required 0/0", imem_addr, inst_valid);
    end
    cycle();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 6'd0 || inst_data !== rom[0] ||
        fetch_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL restart_word: valid=%b pc=%0d data=%h cnt=%0d, required 1/0/%h/%0d",
               inst_valid, inst_pc, inst_data, fetch_count, rom[0], exp_count);
    end
    cycle();
    cycle();
  endtask

  task automatic test_reset_mid();
    RST = 1'b0;
    cycle();
    exp_count = 0;
    n_checks++;
    if (imem_addr !== 6'd0 || inst_valid !== 1'b0 || fetch_count !== 16'd0 ||
        inst_data !== 32'd0 || inst_pc !== 6'd0 || pc_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_values: addr=%0d valid=%b cnt=%0d data=%h pc=%0d wrap=%b, required all 0",
               imem_addr, inst_valid, fetch_count, inst_data, inst_pc, pc_wrap);
    end
    RST = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL midreset_idle: valid=%b addr=%0d, required 0/0", inst_valid, imem_addr);
    end
  endtask

  // Random ready/jump traffic: every accepted word must be the next in-order
  // address, restarting at the jump target after each redirect.
  task automatic test_random();
    logic [AW-1:0] exp_pc;
    int            accepted;
    exp_pc   = 6'd0;
    accepted = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 800; i++) begin
      inst_ready = ($urandom % 4) != 0;
      jump_valid = ($urandom % 16) == 0;
      jump_addr  = AW'($urandom);
      if (inst_valid && inst_ready) begin
        accepted++;
        n_checks++;
        if (inst_pc !== exp_pc || inst_data !== rom[exp_pc]) begin
          n_fail++;
          $display("FAIL rand_order: cycle %0d pc=%0d data=%h, required %0d/%h",
                   i, inst_pc, inst_data, exp_pc, rom[exp_pc]);
        end
        exp_pc = exp_pc + AW'(1);
      end
      if (jump_valid) exp_pc = jump_addr;
      n_checks++;
      if (fetch_count !== 16'(exp_count)) begin
        n_fail++;
        $display("FAIL rand_count: cycle %0d cnt=%0d, required %0d", i, fetch_count, exp_count);
      end
      cycle();
    end
    jump_valid = 1'b0;
    n_checks++;
    if (accepted < 200) begin
      n_fail++;
      $display("FAIL rand_progress: accepted=%0d, required at least 200", accepted);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_inst_fetch_unit
